// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions: glyph patterns, segment bit positions
// and the scan-index one-hot helper.
package seven_seg_pkg;

    localparam int unsigned MAX_DIGITS = 32;

    localparam int unsigned SEG_A  = 7;
    localparam int unsigned SEG_B  = 6;
    localparam int unsigned SEG_C  = 5;
    localparam int unsigned SEG_D  = 4;
    localparam int unsigned SEG_E  = 3;
    localparam int unsigned SEG_F  = 2;
    localparam int unsigned SEG_G  = 1;
    localparam int unsigned SEG_DP = 0;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    // a..g, MSB = a
    localparam logic [6:0] GLYPH_0 = 7'b1111110;
    localparam logic [6:0] GLYPH_1 = 7'b0110000;
    localparam logic [6:0] GLYPH_2 = 7'b1101101;
    localparam logic [6:0] GLYPH_3 = 7'b1111001;
    localparam logic [6:0] GLYPH_4 = 7'b0110011;
    localparam logic [6:0] GLYPH_5 = 7'b1011011;
    localparam logic [6:0] GLYPH_6 = 7'b1011111;
    localparam logic [6:0] GLYPH_7 = 7'b1110000;
    localparam logic [6:0] GLYPH_8 = 7'b1111111;
    localparam logic [6:0] GLYPH_9 = 7'b1111011;
    localparam logic [6:0] GLYPH_A = 7'b1110111;
    localparam logic [6:0] GLYPH_B = 7'b0011111;
    localparam logic [6:0] GLYPH_C = 7'b1001110;
    localparam logic [6:0] GLYPH_D = 7'b0111101;
    localparam logic [6:0] GLYPH_E = 7'b1001111;
    localparam logic [6:0] GLYPH_F = 7'b1000111;

    function automatic logic [MAX_DIGITS-1:0] idx_onehot(input int unsigned i);
        idx_onehot = '0;
        if (i < MAX_DIGITS)
            idx_onehot[i] = 1'b1;
    endfunction

endpackage

// File: rtl/seven_seg_encoder.sv
// Combinational digit encoder: 4-bit code + dp + blank -> {a..g,dp}.
module seven_seg_encoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] code,
    input  logic       dp,
    input  logic       blank,
    input  logic       hex_mode,
    output logic [7:0] seg
);

    logic [6:0] glyph;

    always_comb begin
        glyph = '0;
        case (code)
            4'd0:  glyph = GLYPH_0;
            4'd1:  glyph = GLYPH_1;
            4'd2:  glyph = GLYPH_2;
            4'd3:  glyph = GLYPH_3;
            4'd4:  glyph = GLYPH_4;
            4'd5:  glyph = GLYPH_5;
            4'd6:  glyph = GLYPH_6;
            4'd7:  glyph = GLYPH_7;
            4'd8:  glyph = GLYPH_8;
            4'd9:  glyph = GLYPH_9;
            4'd10: glyph = hex_mode ? GLYPH_A : '0;
            4'd11: glyph = hex_mode ? GLYPH_B : '0;
            4'd12: glyph = hex_mode ? GLYPH_C : '0;
            4'd13: glyph = hex_mode ? GLYPH_D : '0;
            4'd14: glyph = hex_mode ? GLYPH_E : '0;
            4'd15: glyph = hex_mode ? GLYPH_F : '0;
            default: glyph = '0;
        endcase
    end

    always_comb begin
        seg             = SEG_BLANK;
        seg[SEG_A:SEG_G] = blank ? 7'b0 : glyph;
        seg[SEG_DP]     = dp;
    end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed seven-segment scan driver with load-captured hold
// registers, leading-zero blanking and dead time between digit slots.
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int unsigned DIGITS   = 8,
    parameter int unsigned TICK_DIV = 1000,
    parameter int unsigned HEX_MODE = 0
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    input  logic                  en,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     dig_sel,
    output logic                  frame_done
);

    localparam int unsigned IDX_W = $clog2(DIGITS);
    localparam int unsigned CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [4*DIGITS-1:0] hold_data;
    logic [DIGITS-1:0]   hold_dp;
    logic                hold_lz;

    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;
    logic                wrapped;

    logic [DIGITS-1:0]   lz_mask;
    logic                lz_run;
    logic [DIGITS-1:0]   sel_onehot;
    logic [3:0]          cur_code;
    logic                cur_dp;
    logic                cur_blank;
    logic [7:0]          enc_seg;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            hold_data <= '0;
            hold_dp   <= '0;
            hold_lz   <= 1'b0;
        end else if (load) begin
            hold_data <= data_in;
            hold_dp   <= dp_in;
            hold_lz   <= blank_lz;
        end
    end

    // Walk down from the top digit; a digit blanks while every digit at or
    // above it is zero. Digit 0 is never part of the mask.
    always_comb begin
        lz_mask = '0;
        lz_run  = hold_lz;
        for (int unsigned k = 0; k < DIGITS - 1; k++) begin
            lz_run = lz_run && (hold_data[4*(DIGITS-1-k) +: 4] == 4'd0);
            lz_mask[DIGITS-1-k] = lz_run;
        end
    end

    always_comb begin
        cur_code  = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_code  = hold_data[4*i +: 4];
                cur_dp    = hold_dp[i];
                cur_blank = lz_mask[i];
            end
        end
        sel_onehot = DIGITS'(idx_onehot(32'(idx)));
    end

    seven_seg_encoder u_encoder (
        .code     (cur_code),
        .dp       (cur_dp),
        .blank    (cur_blank),
        .hex_mode (HEX_MODE != 0),
        .seg      (enc_seg)
    );

    // wrapped marks the edge that took idx from the last digit back to 0, so
    // a restart from enable (also cnt=0, idx=0) does not raise frame_done.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt        <= '0;
            idx        <= '0;
            wrapped    <= 1'b0;
            seg        <= '0;
            dig_sel    <= '0;
            frame_done <= 1'b0;
        end else if (!en) begin
            cnt        <= '0;
            idx        <= '0;
            wrapped    <= 1'b0;
            seg        <= '0;
            dig_sel    <= '0;
            frame_done <= 1'b0;
        end else begin
            seg        <= enc_seg;
            dig_sel    <= (cnt == '0) ? '0 : sel_onehot;
            frame_done <= wrapped;
            wrapped    <= (cnt == CNT_LAST) && (idx == IDX_LAST);
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver (4 digits, 4-cycle slots), decimal
// and hex variants side by side, checked against a cycle-count scoreboard.
module tb_seven_seg_scan_driver;

    localparam int D = 4;
    localparam int T = 4;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic        en = 1'b0;
    logic [15:0] data_in = '0;
    logic [3:0]  dp_in = '0;

    logic [7:0]  seg_dec, seg_hex;
    logic [3:0]  sel_dec, sel_hex;
    logic        fd_dec, fd_hex;

    seven_seg_scan_driver #(.DIGITS(D), .TICK_DIV(T), .HEX_MODE(0)) u_dec (
        .clk(clk), .nrst(nrst), .load(load), .data_in(data_in), .dp_in(dp_in),
        .blank_lz(blank_lz), .en(en), .seg(seg_dec), .dig_sel(sel_dec),
        .frame_done(fd_dec)
    );

    seven_seg_scan_driver #(.DIGITS(D), .TICK_DIV(T), .HEX_MODE(1)) u_hex (
        .clk(clk), .nrst(nrst), .load(load), .data_in(data_in), .dp_in(dp_in),
        .blank_lz(blank_lz), .en(en), .seg(seg_hex), .dig_sel(sel_hex),
        .frame_done(fd_hex)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] s0;
        logic [7:0] s1;
        logic [3:0] sel;
        logic       fd;
    } exp_t;

    exp_t        sbq[$];
    logic [15:0] m_data = '0;
    logic [3:0]  m_dp = '0;
    logic        m_lz = 1'b0;
    int          m_t = 0;
    int          nchk = 0;
    int          npass = 0;

    function automatic logic [6:0] glyph(input logic [3:0] c, input logic hex);
        case (c)
            4'd0:  return 7'b1111110;
            4'd1:  return 7'b0110000;
            4'd2:  return 7'b1101101;
            4'd3:  return 7'b1111001;
            4'd4:  return 7'b0110011;
            4'd5:  return 7'b1011011;
            4'd6:  return 7'b1011111;
            4'd7:  return 7'b1110000;
            4'd8:  return 7'b1111111;
            4'd9:  return 7'b1111011;
            4'd10: return hex ? 7'b1110111 : 7'b0;
            4'd11: return hex ? 7'b0011111 : 7'b0;
            4'd12: return hex ? 7'b1001110 : 7'b0;
            4'd13: return hex ? 7'b0111101 : 7'b0;
            4'd14: return hex ? 7'b1001111 : 7'b0;
            default: return hex ? 7'b1000111 : 7'b0;
        endcase
    endfunction

    function automatic logic [7:0] exp_seg(input logic [15:0] data, input logic [3:0] dp,
                                           input logic lz, input logic hex, input int d);
        logic blank;
        blank = lz && (d > 0);
        for (int j = d; j < D; j++)
            if (data[4*j +: 4] != 4'd0) blank = 1'b0;
        return {blank ? 7'b0 : glyph(data[4*d +: 4], hex), dp[d]};
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
        nchk++;
        assert (got === want) npass++;
        else $error("FAIL %s: observed %b expected %b", tag, got, want);
    endtask

    // One clock: drive inputs, push the expectation, update the model,
    // then pop and compare just after the edge.
    task automatic step(input logic ld, input logic e);
        exp_t x, got;
        int   dg, ph;
        load = ld;
        en   = e;
        x.s0 = '0; x.s1 = '0; x.sel = '0; x.fd = 1'b0;
        if (e) begin
            dg    = (m_t / T) % D;
            ph    = m_t % T;
            x.s0  = exp_seg(m_data, m_dp, m_lz, 1'b0, dg);
            x.s1  = exp_seg(m_data, m_dp, m_lz, 1'b1, dg);
            x.sel = (ph == 0) ? 4'b0 : 4'(1 << dg);
            x.fd  = (ph == 0) && (dg == 0) && (m_t > 0);
        end
        sbq.push_back(x);
        if (ld) begin
            m_data = data_in;
            m_dp   = dp_in;
            m_lz   = blank_lz;
        end
        m_t = e ? m_t + 1 : 0;
        @(posedge clk);
        #1;
        got = sbq.pop_front();
        chk("seg_dec",     seg_dec,       got.s0);
        chk("seg_hex",     seg_hex,       got.s1);
        chk("dig_sel_dec", 8'(sel_dec),   8'(got.sel));
        chk("dig_sel_hex", 8'(sel_hex),   8'(got.sel));
        chk("frame_done",  8'({fd_hex, fd_dec}), 8'({got.fd, got.fd}));
        load = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_seg_dec"}, seg_dec, 8'h00);
        chk({tag, "_seg_hex"}, seg_hex, 8'h00);
        chk({tag, "_sel"},     8'({sel_hex, sel_dec}), 8'h00);
        chk({tag, "_fd"},      8'({fd_hex, fd_dec}), 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not reach summary (observed timeout, expected finish)");
        $fatal(1, "timeout");
    end

    initial begin
        #2;
        chk_zero("reset");
        #10;
        nrst = 1'b1;
        repeat (3) step(1'b0, 1'b0);

        data_in = 16'h1234; dp_in = 4'b0000; blank_lz = 1'b0;
        step(1'b1, 1'b0);
        run(36);

        while (m_t % 16 != 10) step(1'b0, 1'b1);
        data_in = 16'h5555;
        step(1'b1, 1'b1);
        run(8);

        data_in = 16'h0007; dp_in = 4'b0100; blank_lz = 1'b1;
        step(1'b1, 1'b1);
        run(17);
        data_in = 16'h0000;
        step(1'b1, 1'b1);
        run(17);

        data_in = 16'hABCD; dp_in = 4'b0000; blank_lz = 1'b0;
        step(1'b1, 1'b1);
        run(17);

        while (m_t % 16 != 9) step(1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0);
        run(20);

        #3;
        nrst = 1'b0;
        #1;
        chk_zero("async_rst");
        m_data = '0; m_dp = '0; m_lz = 1'b0; m_t = 0;
        #2;
        nrst = 1'b1;
        repeat (3) step(1'b0, 1'b0);
        run(5);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
